// File: rtl/lut_layer_stream.sv
// lut_layer_stream: streaming LUT neuron layer with runtime-loadable truth tables.
// Each neuron owns a 2**IN_BITS x OUT_BITS table; vectors flow through a
// two-stage registered pipeline (S1 input register, S2 table output register)
// with valid/ready flow control and a saturating transfer counter.
module lut_layer_stream #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 2,
  parameter int NUM_NEURONS = 4,
  parameter int NIDX_W      = 2,
  parameter int CNT_W       = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic [NIDX_W+IN_BITS-1:0]       cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  input  logic                            cfg_commit,
  output logic                            running,
  output logic [CNT_W-1:0]                xfer_count
);

  localparam int DEPTH = 2 ** IN_BITS;
  localparam logic [NIDX_W:0] NUM_N = (NIDX_W + 1)'(NUM_NEURONS);

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state;

  logic [OUT_BITS-1:0]             tbl [NUM_NEURONS][DEPTH];
  logic [NIDX_W-1:0]               cfg_idx;
  logic [IN_BITS-1:0]              cfg_code;
  logic                            cfg_hit;
  logic                            stall;
  logic                            s1_valid;
  logic [NUM_NEURONS*IN_BITS-1:0]  s1_data;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup;

  assign cfg_idx  = cfg_addr[IN_BITS +: NIDX_W];
  assign cfg_code = cfg_addr[IN_BITS-1:0];
  // Writes to a neuron index beyond the layer are dropped; the extra zero bit
  // keeps the comparison meaningful when NUM_NEURONS fills the index range.
  assign cfg_hit  = cfg_we && ({1'b0, cfg_idx} < NUM_N);

  // Output stalls when it holds a vector nobody takes; input is blocked while
  // stalled, while a table write is in progress, or before the tables are committed.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = running & ~cfg_we & ~stall;

  // Configuration FSM: UNCFG until the commit pulse, then RUN until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= UNCFG;
      running <= 1'b0;
    end else begin
      case (state)
        UNCFG: begin
          if (cfg_commit) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          state   <= RUN;
          running <= 1'b1;
        end
        default: begin
          state   <= UNCFG;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Table storage is intentionally not reset so trained contents survive a reset.
  always_ff @(posedge clk) begin
    if (cfg_hit) begin
      tbl[cfg_idx][cfg_code] <= cfg_data;
    end
  end

  // Combinational lookup of every neuron for the vector sitting in S1; a write
  // landing on the same edge is not yet visible, giving read-first behaviour.
  always_comb begin
    lookup = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      lookup[n*OUT_BITS +: OUT_BITS] = tbl[n][s1_data[n*IN_BITS +: IN_BITS]];
    end
  end

  // Two-stage pipeline: both stages advance together whenever the output is not stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid & in_ready;
      if (in_valid && in_ready) begin
        s1_data <= in_data;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= lookup;
      end
    end
  end

  // Saturating count of completed output handshakes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready && (xfer_count != {CNT_W{1'b1}})) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lut_layer_stream.sv
// tb_lut_layer_stream: scoreboard bench for lut_layer_stream.
// A reference copy of the tables predicts each accepted vector's output; the
// prediction is queued at acceptance and compared when the output handshakes.
// A second small instance (3 neurons, 3-bit counter) covers saturation and
// out-of-range neuron writes.
module tb_lut_layer_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        cfg_we;
  logic [9:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        cfg_commit;
  logic        running;
  logic [31:0] xfer_count;

  logic        sm_in_valid;
  logic        sm_in_ready;
  logic [23:0] sm_in_data;
  logic        sm_out_valid;
  logic        sm_out_ready;
  logic [5:0]  sm_out_data;
  logic        sm_cfg_we;
  logic [9:0]  sm_cfg_addr;
  logic [1:0]  sm_cfg_data;
  logic        sm_cfg_commit;
  logic        sm_running;
  logic [2:0]  sm_xfer_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_xfer = 0;
  logic [63:0] sb [$];
  logic [63:0] exp_v;
  logic [1:0]  ref_tbl [4][256];
  bit          hold_chk = 0;
  logic [7:0]  hold_data;

  lut_layer_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .running(running), .xfer_count(xfer_count)
  );

  lut_layer_stream #(
    .IN_BITS(8), .OUT_BITS(2), .NUM_NEURONS(3), .NIDX_W(2), .CNT_W(3)
  ) dut_small (
    .clk(clk), .rst(rst),
    .in_valid(sm_in_valid), .in_ready(sm_in_ready), .in_data(sm_in_data),
    .out_valid(sm_out_valid), .out_ready(sm_out_ready), .out_data(sm_out_data),
    .cfg_we(sm_cfg_we), .cfg_addr(sm_cfg_addr), .cfg_data(sm_cfg_data),
    .cfg_commit(sm_cfg_commit), .running(sm_running), .xfer_count(sm_xfer_count)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] d);
    logic [7:0] r;
    r = '0;
    for (int n = 0; n < 4; n++) r[n*2 +: 2] = ref_tbl[n][d[n*8 +: 8]];
    return 64'(r);
  endfunction

  task automatic cfgWrite(input int idx, input int code, input logic [1:0] val, input logic commit);
    cfg_we     = 1'b1;
    cfg_addr   = {2'(idx), 8'(code)};
    cfg_data   = val;
    cfg_commit = commit;
    @(posedge clk); #1;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    if (idx < 4) ref_tbl[idx][code] = val;
  endtask

  task automatic applyStimulus(input logic [31:0] d);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) checkOutput("drain_timeout", 64'(1), 64'(0));
  endtask

  // Scoreboard monitor: predicts on input handshakes, compares on output
  // handshakes, and checks that a stalled output holds its vector.
  always @(negedge clk) begin
    if (rst) begin
      if (hold_chk) begin
        checkOutput("hold_valid", 64'(out_valid), 64'(1));
        checkOutput("hold_data", 64'(out_data), 64'(hold_data));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("ghost_out", 64'(1), 64'(0));
        end else begin
          exp_v = sb.pop_front();
          checkOutput("out_data", 64'(out_data), exp_v);
        end
        exp_xfer++;
      end
      if (in_valid && in_ready) sb.push_back(model(in_data));
      hold_chk  = out_valid && !out_ready;
      hold_data = out_data;
    end else begin
      hold_chk = 0;
    end
  end

  // Safety net so the run always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [3:0] pat;
    int         base;
    int         sent;
    int         got;
    pat = 4'b1001;
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    sm_in_valid = 1'b0; sm_in_data = '0; sm_out_ready = 1'b1;
    sm_cfg_we = 1'b0; sm_cfg_addr = '0; sm_cfg_data = '0; sm_cfg_commit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_running", 64'(running), 64'(0));
    checkOutput("rst_xfer", 64'(xfer_count), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    $display("[TB] gating before commit");
    in_valid = 1'b1;
    in_data  = 32'h0C0C_0C0C;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("uncfg_in_ready", 64'(in_ready), 64'(0));
      checkOutput("uncfg_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("[TB] programming tables");
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 256; c++) begin
        if (n == 0) cfgWrite(n, c, (c == 12) ? 2'b00 : 2'b11, 1'b0);
        else        cfgWrite(n, c, 2'(c + n), 1'b0);
      end
    end
    for (int n = 1; n < 4; n++) cfgWrite(n, 255, 2'(n), 1'b0);
    cfgWrite(0, 255, 2'b00, 1'b1);
    @(negedge clk);
    checkOutput("running_after_commit", 64'(running), 64'(1));
    checkOutput("in_ready_after_commit", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    $display("[TB] channel isolation and basic stream");
    applyStimulus(32'hFFFF_FFFF);
    waitDrain();
    checkOutput("isolation_last", 64'(out_data), 64'(8'b11_10_01_00));
    applyStimulus(32'h0000_000C);
    @(negedge clk);
    checkOutput("lat_cycle1", 64'(out_valid), 64'(0));
    @(negedge clk);
    checkOutput("lat_cycle2", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    applyStimulus(32'h0000_000D);
    waitDrain();
    checkOutput("xfer_basic", 64'(xfer_count), 64'(3));

    $display("[TB] write collision");
    applyStimulus(32'h0000_0007);
    cfg_we = 1'b1; cfg_addr = {2'd0, 8'h07}; cfg_data = 2'b01;
    @(negedge clk);
    checkOutput("collide_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    cfg_we = 1'b0;
    ref_tbl[0][7] = 2'b01;
    applyStimulus(32'h0000_0007);
    waitDrain();

    $display("[TB] backpressure");
    base = exp_xfer;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus($urandom);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = pat[k % 4];
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    waitDrain();
    checkOutput("xfer_bp", 64'(xfer_count), 64'(base + 8));

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(32'h0000_000C);
    applyStimulus(32'hFFFF_FFFF);
    rst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    exp_xfer = 0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midrst_xfer", 64'(xfer_count), 64'(0));
    checkOutput("midrst_running", 64'(running), 64'(0));
    checkOutput("midrst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    applyStimulus(32'hFFFF_FFFF);
    applyStimulus(32'h0000_000C);
    applyStimulus(32'h0000_0007);
    for (int i = 0; i < 4; i++) applyStimulus($urandom);
    waitDrain();
    checkOutput("xfer_after_rst", 64'(xfer_count), 64'(7));

    $display("[TB] small instance: out-of-range write and saturation");
    for (int n = 0; n < 4; n++) begin
      sm_cfg_we   = 1'b1;
      sm_cfg_addr = {2'(n), 8'h05};
      sm_cfg_data = (n == 3) ? 2'b00 : 2'(n + 1);
      @(posedge clk); #1;
    end
    sm_cfg_we = 1'b0;
    sm_cfg_commit = 1'b1;
    @(posedge clk); #1;
    sm_cfg_commit = 1'b0;
    sm_in_data  = {3{8'h05}};
    sm_in_valid = 1'b1;
    sent = 0;
    got  = 0;
    for (int k = 0; k < 80 && got < 10; k++) begin
      @(negedge clk);
      if (sm_in_valid && sm_in_ready) sent++;
      if (sm_out_valid && sm_out_ready) begin
        got++;
        checkOutput("sm_data", 64'(sm_out_data), 64'(6'b11_10_01));
      end
      @(posedge clk); #1;
      if (sent >= 10) sm_in_valid = 1'b0;
    end
    checkOutput("sm_transfers", 64'(got), 64'(10));
    @(negedge clk);
    checkOutput("sm_xfer_sat", 64'(sm_xfer_count), 64'(7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
